// File: rtl/bip_seq_defs.sv
// Shared definitions for the BIP run/step sequencer: command bytes,
// FSM state encoding, report length and the status-byte layout.
package bip_seq_defs;

  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'

  localparam int REPORT_LEN = 7;
  localparam int SNAP_W     = REPORT_LEN * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_STEP,
    ST_REPORT
  } seq_state_t;

  // Last report byte: {6'b0, timeout, halted}
  function automatic logic [7:0] status_byte(input logic timeout, input logic halted);
    return {6'b0, timeout, halted};
  endfunction

endpackage

// File: rtl/report_serializer.sv
// Report serializer: captures the 56-bit status snapshot and sends it
// MSB byte first over a valid/ready byte stream. After each accepted
// byte tx_valid drops for one cycle before the next byte is presented.
module report_serializer
  import bip_seq_defs::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [SNAP_W-1:0] i_snap,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_done
);

  localparam logic [2:0] LAST_IDX = 3'(REPORT_LEN - 1);

  logic [SNAP_W-9:0] r_shift;
  logic [7:0]        r_data;
  logic [2:0]        r_idx;
  logic              r_valid;
  logic              r_pend;
  logic              w_accept;

  assign w_accept   = r_valid & i_tx_ready;
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_data;
  assign o_done     = w_accept & (r_idx == LAST_IDX);

  // Load snapshot, hold each byte until accepted, then present the next one
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_data  <= 8'h00;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_snap[SNAP_W-1 -: 8];
      r_shift <= i_snap[SNAP_W-9:0];
      r_idx   <= 3'd0;
      r_valid <= 1'b1;
      r_pend  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_pend  <= (r_idx != LAST_IDX);
    end else if (r_pend) begin
      r_data  <= r_shift[SNAP_W-9 -: 8];
      r_shift <= {r_shift[SNAP_W-17:0], 8'h00};
      r_idx   <= r_idx + 3'd1;
      r_valid <= 1'b1;
      r_pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/bip_exec_sequencer.sv
// BIP run/step sequencer: decodes clear/run/step command bytes, gates the
// CPU through cpu_en, stops on the HALT opcode, counts executed cycles and
// sends a 7-byte status report after every run or step.
// Optional feature macro: BIP_WATCHDOG_EN (run-length limit WDOG_LIMIT,
// armed after each clear; sets the timeout status bit when it trips).
module bip_exec_sequencer
  import bip_seq_defs::*;
#(
  parameter int                       addrLength    = 11,
  parameter int                       OPCODE_LENGTH = 5,
  parameter int                       DATA_WIDTH    = 16,
  parameter int                       CYCLE_WIDTH   = 16,
  parameter logic [OPCODE_LENGTH-1:0] HALT_OPCODE   = '0,
  parameter logic [15:0]              WDOG_LIMIT    = 16'hFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_byte,
  input  logic [OPCODE_LENGTH-1:0] cpu_opcode,
  input  logic [addrLength-1:0]    cpu_pc,
  input  logic [DATA_WIDTH-1:0]    cpu_acc,
  output logic                     cpu_en,
  output logic                     cpu_reset,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     halted
);

`ifdef BIP_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam logic [CYCLE_WIDTH-1:0] WDOG_CNT = CYCLE_WIDTH'(WDOG_LIMIT);

  seq_state_t             r_state;
  logic [CYCLE_WIDTH-1:0] r_cnt;
  logic                   r_halted;
  logic                   r_timeout;
  logic                   r_cpu_reset;
  logic                   r_load;

  logic                   w_is_halt;
  logic                   w_wdog_hit;
  logic                   w_cnt_max;
  logic                   w_done;
  logic [SNAP_W-1:0]      w_snap;

  assign w_is_halt  = (cpu_opcode == HALT_OPCODE);
  // Watchdog fires once per clear: the timeout bit itself disarms it
  assign w_wdog_hit = WDOG_EN && !r_timeout && (r_cnt == WDOG_CNT);
  assign w_cnt_max  = &r_cnt;

  // Combinational so the HALT instruction itself is never executed
  assign cpu_en = !w_is_halt &&
                  ((r_state == ST_STEP) || ((r_state == ST_RUN) && !w_wdog_hit));

  assign w_snap = {16'(cpu_pc), 16'(cpu_acc), 16'(r_cnt),
                   status_byte(r_timeout, r_halted)};

  assign cpu_reset = r_cpu_reset;
  assign busy      = (r_state != ST_IDLE);
  assign halted    = r_halted;

  // Sequencer FSM with cycle counter, halted/timeout flags and report trigger
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_load      <= 1'b0;
    end else begin
      r_cpu_reset <= 1'b0;
      r_load      <= 1'b0;
      if (cpu_en && !w_cnt_max) r_cnt <= r_cnt + CYCLE_WIDTH'(1);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_byte)
              CMD_CLEAR: begin
                r_state     <= ST_CLR;
                r_cpu_reset <= 1'b1;
                r_cnt       <= '0;
                r_halted    <= 1'b0;
                r_timeout   <= 1'b0;
              end
              CMD_RUN: begin
                r_state <= r_halted ? ST_REPORT : ST_RUN;
                r_load  <= r_halted;
              end
              CMD_STEP: begin
                r_state <= r_halted ? ST_REPORT : ST_STEP;
                r_load  <= r_halted;
              end
              default: ;
            endcase
          end
        end
        ST_CLR: r_state <= ST_IDLE;
        ST_RUN: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_REPORT;
            r_load   <= 1'b1;
          end else if (w_wdog_hit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_REPORT;
            r_load    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (w_is_halt) r_halted <= 1'b1;
          r_state <= ST_REPORT;
          r_load  <= 1'b1;
        end
        ST_REPORT: if (w_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  report_serializer u_report (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (r_load),
    .i_snap     (w_snap),
    .i_tx_ready (tx_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .o_done     (w_done)
  );

endmodule
